// File: rtl/mem_responder_pkg.sv
// Shared definitions for the SRAM memory responder: FSM state codes,
// default wait-state counts and the idle levels of the SRAM pins.
package mem_responder_pkg;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_RD    = 3'd2;
  localparam logic [2:0] ST_WR    = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  // Default access lengths in clock cycles (legal range 1..15)
  localparam int WAIT_RD_DEFAULT = 2;
  localparam int WAIT_WR_DEFAULT = 1;

  // Idle (released) levels of the SRAM pins
  localparam logic        STROBE_OFF = 1'b1;
  localparam logic [3:0]  BE_N_IDLE  = 4'hF;
  localparam logic [31:0] DQ_IDLE    = 32'h0000_0000;

  // Value loaded into the wait counter so that it reaches zero on the
  // last cycle of an access lasting `cycles` clocks.
  function automatic logic [3:0] wait_load(input int cycles);
    return 4'(cycles - 1);
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable 4-bit down-counter used to time SRAM strobe widths.
// Load has priority; the count stops at zero.
module mem_wait_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       en,
  input  logic [3:0] load_value,
  output logic       zero
);

  logic [3:0] count;

  // Count register: load, then decrement while enabled until zero
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != 4'd0)) begin
      count <= count - 4'd1;
    end
  end

  assign zero = (count == 4'd0);

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: serves one word request at a time against an
// asynchronous SRAM. Every SRAM pin and the done/err/rdata outputs come
// straight from flops that are updated from the current FSM state, so a
// pin lags its state by one clock and no request input reaches a pin
// combinationally. Out-of-range requests pass through SETUP with all
// strobes gated off, so they never touch the SRAM.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int SRAM_AW = 18,
  parameter int WAIT_RD = WAIT_RD_DEFAULT,
  parameter int WAIT_WR = WAIT_WR_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [29:0]        adr,
  input  logic [31:0]        wdata,
  input  logic [3:0]         byteen,
  input  logic               rwb,
  input  logic               en,
  output logic               done,
  output logic [31:0]        rdata,
  output logic               err,
  output logic [SRAM_AW-1:0] sram_adr,
  input  logic [31:0]        sram_dq_i,
  output logic [31:0]        sram_dq_o,
  output logic               sram_dq_oe,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic [3:0]         sram_be_n
);

  logic [2:0]         state;
  logic [2:0]         next_state;
  logic [SRAM_AW-1:0] adr_q;
  logic [31:0]        wdata_q;
  logic [3:0]         byteen_q;
  logic               rwb_q;
  logic               err_q;
  logic               capture;
  logic               out_of_range;
  logic               access;
  logic               cnt_load;
  logic               cnt_en;
  logic               cnt_zero;
  logic [3:0]         cnt_value;

  assign capture      = (state == ST_IDLE) && en;
  assign out_of_range = |adr[29:SRAM_AW];

  // An access is in progress on the SRAM bus in these states
  assign access = !err_q && ((state == ST_SETUP) || (state == ST_RD) ||
                             (state == ST_WR)    || (state == ST_HOLD));

  assign cnt_load  = (state == ST_SETUP) && !err_q;
  assign cnt_en    = (state == ST_RD) || (state == ST_WR);
  assign cnt_value = rwb_q ? wait_load(WAIT_RD) : wait_load(WAIT_WR);

  mem_wait_counter u_wait (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load),
    .en         (cnt_en),
    .load_value (cnt_value),
    .zero       (cnt_zero)
  );

  // Next-state decode
  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (en) next_state = ST_SETUP;
      ST_SETUP: begin
        if (err_q)      next_state = ST_DONE;
        else if (rwb_q) next_state = ST_RD;
        else            next_state = ST_WR;
      end
      ST_RD:    if (cnt_zero) next_state = ST_DONE;
      ST_WR:    if (cnt_zero) next_state = ST_HOLD;
      ST_HOLD:  next_state = ST_DONE;
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Request capture; inputs are ignored until the request completes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      adr_q    <= '0;
      wdata_q  <= '0;
      byteen_q <= '0;
      rwb_q    <= 1'b0;
      err_q    <= 1'b0;
    end else if (capture) begin
      adr_q    <= adr[SRAM_AW-1:0];
      wdata_q  <= wdata;
      byteen_q <= byteen;
      rwb_q    <= rwb;
      err_q    <= out_of_range;
    end
  end

  // SRAM pin flops, driven from the current state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sram_adr   <= '0;
      sram_dq_o  <= DQ_IDLE;
      sram_dq_oe <= 1'b0;
      sram_ce_n  <= STROBE_OFF;
      sram_oe_n  <= STROBE_OFF;
      sram_we_n  <= STROBE_OFF;
      sram_be_n  <= BE_N_IDLE;
    end else begin
      if (cnt_load) begin
        sram_adr <= adr_q;
        if (!rwb_q) sram_dq_o <= wdata_q;
      end
      sram_ce_n  <= !access;
      sram_oe_n  <= !(access && (state == ST_RD));
      sram_we_n  <= !(access && (state == ST_WR) && (byteen_q != 4'b0000));
      sram_dq_oe <= access && !rwb_q;
      if (!access)    sram_be_n <= BE_N_IDLE;
      else if (rwb_q) sram_be_n <= 4'b0000;
      else            sram_be_n <= ~byteen_q;
    end
  end

  // Completion outputs; read data is sampled while oe_n is still low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done  <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      done <= (state == ST_DONE);
      err  <= (state == ST_DONE) && err_q;
      if ((state == ST_DONE) && rwb_q && !err_q) rdata <= sram_dq_i;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: a behavioural SRAM, a word model
// of memory contents, and a scoreboard of expected completions.
module tb_mem_responder;

  localparam int AW   = 18;
  localparam int W_RD = 2;
  localparam int W_WR = 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [29:0]   adr = '0;
  logic [31:0]   wdata = '0;
  logic [3:0]    byteen = '0;
  logic          rwb = 1'b0;
  logic          en = 1'b0;
  logic          done;
  logic [31:0]   rdata;
  logic          err;
  logic [AW-1:0] sram_adr;
  logic [31:0]   sram_dq_i;
  logic [31:0]   sram_dq_o;
  logic          sram_dq_oe;
  logic          sram_ce_n;
  logic          sram_oe_n;
  logic          sram_we_n;
  logic [3:0]    sram_be_n;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          ce_cnt;
    int          oe_cnt;
    int          we_cnt;
    int          dqoe_cnt;
    logic [3:0]  be_n;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] sram  [0:4095];
  logic [31:0] model [0:4095];
  logic [31:0] last_rdata = '0;

  mem_responder #(.SRAM_AW(AW), .WAIT_RD(W_RD), .WAIT_WR(W_WR)) dut (
    .clk        (clk),
    .reset      (reset),
    .adr        (adr),
    .wdata      (wdata),
    .byteen     (byteen),
    .rwb        (rwb),
    .en         (en),
    .done       (done),
    .rdata      (rdata),
    .err        (err),
    .sram_adr   (sram_adr),
    .sram_dq_i  (sram_dq_i),
    .sram_dq_o  (sram_dq_o),
    .sram_dq_oe (sram_dq_oe),
    .sram_ce_n  (sram_ce_n),
    .sram_oe_n  (sram_oe_n),
    .sram_we_n  (sram_we_n),
    .sram_be_n  (sram_be_n)
  );

  always #5 clk = ~clk;

  // Behavioural asynchronous SRAM
  assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? sram[sram_adr[11:0]] : 32'h0BAD_0BAD;

  initial begin
    for (int i = 0; i < 4096; i++) sram[i] <= 32'h0;
    sram[12'h0AD] <= 32'hBEADBEEF;
  end

  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n)
      for (int i = 0; i < 4; i++)
        if (!sram_be_n[i]) sram[sram_adr[11:0]][8*i +: 8] <= sram_dq_o[8*i +: 8];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive a request and push its expected completion
  task automatic start_req(input logic r, input logic [29:0] a,
                           input logic [31:0] d, input logic [3:0] be);
    exp_t e;
    logic oor;
    oor = (a[29:AW] != '0);
    adr = a; wdata = d; byteen = be; rwb = r; en = 1'b1;
    e.err = oor;
    e.be_n = r ? 4'b0000 : ~be;
    if (oor) begin
      e.lat = 2; e.ce_cnt = 0; e.oe_cnt = 0; e.we_cnt = 0; e.dqoe_cnt = 0;
    end else if (r) begin
      e.lat = 2 + W_RD; e.ce_cnt = 1 + W_RD; e.oe_cnt = W_RD;
      e.we_cnt = 0; e.dqoe_cnt = 0;
      last_rdata = model[a[11:0]];
    end else begin
      e.lat = 3 + W_WR; e.ce_cnt = 2 + W_WR; e.oe_cnt = 0;
      e.we_cnt = (be != 4'b0000) ? W_WR : 0; e.dqoe_cnt = 2 + W_WR;
      for (int i = 0; i < 4; i++)
        if (be[i]) model[a[11:0]][8*i +: 8] = d[8*i +: 8];
    end
    e.rdata = last_rdata;
    sb.push_back(e);
  endtask

  // Wait for done, observe strobes, and compare against the scoreboard head
  task automatic wait_done(input string name, input bit drop_en);
    exp_t e;
    int   k;
    int   ce = 0, oe = 0, we = 0, dqoe = 0;
    logic [3:0] be_seen = 4'hF;
    bit   got = 0, contention = 0;
    for (k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        vectors++;
        if ({done, sram_ce_n} !== 2'b01) begin
          miscompares++;
          $display("FAIL %s capture-cycle idle: done,ce_n=%b expected 01", name, {done, sram_ce_n});
        end
      end
      if (!sram_ce_n) begin ce++; be_seen = sram_be_n; end
      if (!sram_oe_n) oe++;
      if (!sram_we_n) we++;
      if (sram_dq_oe) dqoe++;
      if (sram_dq_oe && !sram_oe_n) contention = 1;
      if (done) begin got = 1; break; end
    end
    e = sb.pop_front();
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL %s timeout: no done within 40 cycles", name);
    end else begin
      vectors++;
      if (k !== e.lat) begin miscompares++; $display("FAIL %s latency: got %0d expected %0d", name, k, e.lat); end
      vectors++;
      if (err !== e.err) begin miscompares++; $display("FAIL %s err: got %b expected %b", name, err, e.err); end
      vectors++;
      if (rdata !== e.rdata) begin miscompares++; $display("FAIL %s rdata: got %h expected %h", name, rdata, e.rdata); end
      vectors++;
      if (ce !== e.ce_cnt) begin miscompares++; $display("FAIL %s ce_n low cycles: got %0d expected %0d", name, ce, e.ce_cnt); end
      vectors++;
      if (oe !== e.oe_cnt) begin miscompares++; $display("FAIL %s oe_n low cycles: got %0d expected %0d", name, oe, e.oe_cnt); end
      vectors++;
      if (we !== e.we_cnt) begin miscompares++; $display("FAIL %s we_n low cycles: got %0d expected %0d", name, we, e.we_cnt); end
      vectors++;
      if (dqoe !== e.dqoe_cnt) begin miscompares++; $display("FAIL %s dq_oe cycles: got %0d expected %0d", name, dqoe, e.dqoe_cnt); end
      vectors++;
      if (contention) begin miscompares++; $display("FAIL %s contention: dq_oe with oe_n low, expected none", name); end
      vectors++;
      if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe} !== 4'b1110) begin
        miscompares++;
        $display("FAIL %s release at done: ce,oe,we,dqoe=%b expected 1110", name,
                 {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe});
      end
      if (e.ce_cnt > 0) begin
        vectors++;
        if (be_seen !== e.be_n) begin miscompares++; $display("FAIL %s be_n: got %b expected %b", name, be_seen, e.be_n); end
      end
    end
    if (drop_en) en = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({done, err, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n} !== 10'b000_111_1111) begin
      miscompares++;
      $display("FAIL reset strobes: got %b expected 0001111111",
               {done, err, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n});
    end
    vectors++;
    if (rdata !== 32'h0) begin miscompares++; $display("FAIL reset rdata: got %h expected 0", rdata); end
    vectors++;
    if (sram_adr !== '0) begin miscompares++; $display("FAIL reset sram_adr: got %h expected 0", sram_adr); end
    vectors++;
    if (sram_dq_o !== 32'h0) begin miscompares++; $display("FAIL reset dq_o: got %h expected 0", sram_dq_o); end
    reset = 1'b1;
  endtask

  task automatic test_read();
    @(negedge clk); start_req(1'b1, 30'h00AD, 32'h0, 4'h0); wait_done("read_00AD", 1'b1);
  endtask

  task automatic test_write();
    @(negedge clk); start_req(1'b0, 30'h04AD, 32'hDDCCBBAA, 4'b1111); wait_done("write_04AD", 1'b1);
    @(negedge clk); start_req(1'b1, 30'h04AD, 32'h0, 4'h0); wait_done("readback_04AD", 1'b1);
  endtask

  task automatic test_partial();
    @(negedge clk); start_req(1'b0, 30'h04AD, 32'h11223344, 4'b0101); wait_done("write_be0101", 1'b1);
    @(negedge clk); start_req(1'b1, 30'h04AD, 32'h0, 4'h0); wait_done("readback_be0101", 1'b1);
    @(negedge clk); start_req(1'b0, 30'h04AD, 32'hFFFFFFFF, 4'b0000); wait_done("write_be0000", 1'b1);
    @(negedge clk); start_req(1'b1, 30'h04AD, 32'h0, 4'h0); wait_done("readback_be0000", 1'b1);
  endtask

  task automatic test_out_of_range();
    @(negedge clk); start_req(1'b1, 30'h20000000, 32'h0, 4'h0); wait_done("oor_read", 1'b1);
    @(negedge clk); start_req(1'b0, 30'h00040000, 32'h12345678, 4'hF); wait_done("oor_write", 1'b1);
  endtask

  task automatic test_back_to_back();
    @(negedge clk); start_req(1'b0, 30'h0123, 32'hCAFEF00D, 4'b1111); wait_done("b2b_write", 1'b0);
    start_req(1'b1, 30'h0123, 32'h0, 4'h0); wait_done("b2b_read", 1'b0);
    start_req(1'b1, 30'h00AD, 32'h0, 4'h0); wait_done("b2b_read2", 1'b1);
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk); start_req(1'b1, 30'h04AD, 32'h0, 4'h0);
    repeat (3) begin @(posedge clk); #1; end
    vectors++;
    if (sram_oe_n !== 1'b0) begin miscompares++; $display("FAIL midread oe_n before reset: got %b expected 0", sram_oe_n); end
    reset = 1'b0;
    #1;
    vectors++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, done} !== 5'b11100) begin
      miscompares++;
      $display("FAIL midread async release: ce,oe,we,dqoe,done=%b expected 11100",
               {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, done});
    end
    vectors++;
    if (rdata !== 32'h0) begin miscompares++; $display("FAIL midread rdata: got %h expected 0", rdata); end
    en = 1'b0;
    void'(sb.pop_back());
    last_rdata = 32'h0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); start_req(1'b1, 30'h00AD, 32'h0, 4'h0); wait_done("read_after_reset", 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) model[i] = 32'h0;
    model[12'h0AD] = 32'hBEADBEEF;
    test_reset();
    test_read();
    test_write();
    test_partial();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid_read();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
